// File: rtl/weight_bank_array.sv
// rtl/weight_bank_array.sv - multi-bank weight store filled round-robin from a word stream; optional WEIGHT_MEM_CHKSUM_EN adds load_checksum
module weight_bank_array #(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_DEPTH = 2048,
  parameter int LAYER_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            csen,
  input  logic                            load_start,
  input  logic [LAYER_W-1:0]              load_layer,
  input  logic [ADDR_WIDTH:0]             load_len,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            load_busy,
  output logic                            load_done,
  output logic [LAYER_W-1:0]              loaded_layer,
  output logic                            loaded,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rd_valid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data
`ifdef WEIGHT_MEM_CHKSUM_EN
  ,
  output logic [15:0]                     load_checksum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int MEM_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L     = (ADDR_WIDTH + 1)'(1);

  logic [1:0]            state_q, state_d;
  logic [LAYER_W-1:0]    tag_q, tag_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [BANK_W-1:0]     bank_ptr_q, bank_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
  logic [LAYER_W-1:0]    loaded_layer_q;
  logic                  loaded_q;
  logic                  rd_valid_q;
  logic                  rd_hit_q;

  logic accept;
  logic last_word;
  logic start_ok;
  logic rd_fire;
  logic rd_in_range;

  assign wr_ready    = (state_q == S_LOAD) && csen;
  assign accept      = wr_valid && wr_ready;
  assign start_ok    = (state_q == S_IDLE) && load_start && csen;
  assign last_word   = (bank_ptr_q == LAST_BANK) && ({1'b0, addr_ptr_q} == (len_q - ONE_L));
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign rd_fire     = rd_en && csen && (state_q == S_IDLE);

  assign load_busy    = (state_q == S_LOAD);
  assign load_done    = (state_q == S_DONE);
  assign loaded_layer = loaded_layer_q;
  assign loaded       = loaded_q;
  assign rd_valid     = rd_valid_q;

  // Load FSM next state and round-robin write pointers.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    len_d      = len_q;
    bank_ptr_d = bank_ptr_q;
    addr_ptr_d = addr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          tag_d      = load_layer;
          len_d      = (load_len > DEPTH_L) ? DEPTH_L : load_len;
          bank_ptr_d = '0;
          addr_ptr_d = '0;
          state_d    = (load_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (last_word) state_d = S_DONE;
          if (bank_ptr_q == LAST_BANK) begin
            bank_ptr_d = '0;
            addr_ptr_d = addr_ptr_q + ADDR_WIDTH'(1);
          end else begin
            bank_ptr_d = bank_ptr_q + BANK_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers, completion status and read-valid pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tag_q          <= '0;
      len_q          <= '0;
      bank_ptr_q     <= '0;
      addr_ptr_q     <= '0;
      loaded_layer_q <= '0;
      loaded_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_hit_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      len_q      <= len_d;
      bank_ptr_q <= bank_ptr_d;
      addr_ptr_q <= addr_ptr_d;
      if (state_q == S_DONE) begin
        loaded_layer_q <= tag_q;
        loaded_q       <= 1'b1;
      end
      rd_valid_q <= rd_fire;
      rd_hit_q   <= rd_fire && rd_in_range;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Unreset RAM: write when the stream word lands in this bank, registered read.
    always_ff @(posedge clk) begin
      if (accept && (bank_ptr_q == BANK_W'(b))) mem[addr_ptr_q[MEM_AW-1:0]] <= wr_data;
      if (rd_fire && rd_in_range) rdata_q <= mem[rd_addr[MEM_AW-1:0]];
    end

    // Out-of-range, dropped and reset reads present zero regardless of RAM output.
    assign rd_data[b*DATA_WIDTH +: DATA_WIDTH] = rd_hit_q ? rdata_q : '0;
  end

`ifdef WEIGHT_MEM_CHKSUM_EN
  localparam int CW = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
  logic [CW-1:0] word_ext;
  logic [15:0]   chk_q;

  assign word_ext      = CW'(wr_data);
  assign load_checksum = chk_q;

  // Running mod-2^16 sum of accepted words, cleared when a load starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (start_ok) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= chk_q + word_ext[15:0];
    end
  end
`else
  // Checksum port and adder are absent in this build.
`endif

endmodule

// File: tb/tb_weight_bank_array.sv
// tb/tb_weight_bank_array.sv - directed self-checking bench for weight_bank_array
module tb_weight_bank_array;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int DEPTH = 2048;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              csen;
  logic              load_start;
  logic [LW-1:0]     load_layer;
  logic [AW:0]       load_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DW-1:0]     wr_data;
  logic              load_busy;
  logic              load_done;
  logic [LW-1:0]     loaded_layer;
  logic              loaded;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [NB*DW-1:0]  rd_data;
`ifdef WEIGHT_MEM_CHKSUM_EN
  logic [15:0]       load_checksum;
`endif

  weight_bank_array #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .LAYER_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csen(csen),
    .load_start(load_start), .load_layer(load_layer), .load_len(load_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .load_busy(load_busy), .load_done(load_done),
    .loaded_layer(loaded_layer), .loaded(loaded),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef WEIGHT_MEM_CHKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int b0, d0;

  always @(posedge clk) begin
    if (load_busy) busy_cnt++;
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start_load(input logic [LW-1:0] layer, input int len);
    load_start = 1'b1;
    load_layer = layer;
    load_len   = (AW + 1)'(len);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [7:0] base, input int step, input bit gaps, input bit blk);
    int sent = 0;
    int cyc = 0;
    int drop_left = 0;
    bit dropped = 1'b0;
    bit acc;
    while (sent < n && cyc < n * 8 + 20) begin
      if (gaps && !dropped && sent == 5) begin
        drop_left = 3;
        dropped = 1'b1;
      end
      csen     = (drop_left == 0);
      wr_valid = (drop_left > 0) ? 1'b1 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      wr_data  = 8'(base + step * sent);
      if (blk) begin
        check("blk_valid", rd_valid, 0);
        check("blk_data", rd_data, 0);
      end
      #1;
      if (!csen) check("ready_csen_low", wr_ready, 0);
      acc = wr_valid && wr_ready;
      @(negedge clk);
      if (acc) sent++;
      if (drop_left > 0) drop_left--;
      cyc++;
    end
    wr_valid = 1'b0;
    csen = 1'b1;
    if (sent < n) check("stream_timeout", sent, n);
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    @(negedge clk);
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, exp);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_ready"}, wr_ready, 0);
    check({tag, "_busy"}, load_busy, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_rvalid"}, rd_valid, 0);
    check({tag, "_loaded"}, loaded, 0);
    check({tag, "_layer"}, loaded_layer, 0);
    check({tag, "_rdata"}, rd_data, 0);
`ifdef WEIGHT_MEM_CHKSUM_EN
    check({tag, "_chksum"}, load_checksum, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; csen = 1'b0; load_start = 1'b0; load_layer = '0; load_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    reset_outputs("reset");
    rst_n = 1'b1;
    csen = 1'b1;
    @(negedge clk);

    // basic load: 12 words 0x01..0x0C over 4 banks, len 3
    start_load(4'h5, 3);
    check("basic_busy", load_busy, 1);
    check("basic_ready", wr_ready, 1);
    b0 = busy_cnt;
    d0 = done_cnt;
    stream(12, 8'h01, 1, 1'b0, 1'b0);
    check("basic_done", load_done, 1);
    check("basic_load_cycles", busy_cnt - b0, 12);
    check("basic_busy_off", load_busy, 0);
`ifdef WEIGHT_MEM_CHKSUM_EN
    check("basic_chksum", load_checksum, 16'h004E);
`endif
    @(negedge clk);
    check("basic_done_clear", load_done, 0);
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_loaded", loaded, 1);
    check("basic_layer", loaded_layer, 5);
    rd_chk("basic_a0", 0, 32'h04030201);
    rd_chk("basic_a1", 1, 32'h08070605);
    rd_chk("basic_a2", 2, 32'h0C0B0A09);
    rd_en = 1'b0;
    @(negedge clk);
    check("idle_rvalid", rd_valid, 0);
    check("idle_rdata", rd_data, 0);
    check("basic_done_still_once", done_cnt - d0, 1);

    // backpressure: random wr_valid gaps and a 3-cycle csen drop
    start_load(4'h9, 3);
    stream(12, 8'h01, 1, 1'b1, 1'b0);
    check("bp_done", load_done, 1);
    @(negedge clk);
    check("bp_layer", loaded_layer, 9);
    rd_chk("bp_a0", 0, 32'h04030201);
    rd_chk("bp_a1", 1, 32'h08070605);
    rd_chk("bp_a2", 2, 32'h0C0B0A09);
    rd_en = 1'b0;
    @(negedge clk);

    // blocked reads: rd_en held through LOAD and DONE
    start_load(4'h2, 1);
    rd_en = 1'b1;
    rd_addr = '0;
    stream(4, 8'hA0, 1, 1'b0, 1'b1);
    check("blk_done", load_done, 1);
    check("blk_valid_done", rd_valid, 0);
    @(negedge clk);
    check("blk_valid_idle0", rd_valid, 0);
    check("blk_data_idle0", rd_data, 0);
    @(negedge clk);
    check("blk_first_valid", rd_valid, 1);
    check("blk_first_data", rd_data, 32'hA3A2A1A0);
    rd_chk("blk_keep_a1", 1, 32'h08070605);
    rd_en = 1'b0;
    @(negedge clk);

    // zero length: LOAD skipped, memory untouched
    start_load(4'h6, 0);
    check("len0_done", load_done, 1);
    check("len0_busy", load_busy, 0);
    check("len0_ready", wr_ready, 0);
    @(negedge clk);
    check("len0_layer", loaded_layer, 6);
    rd_chk("len0_a0", 0, 32'hA3A2A1A0);

    // out-of-range reads
    rd_chk("oor_2048", 2048, 32'h0);
    rd_chk("oor_4095", 4095, 32'h0);
    rd_en = 1'b0;
    @(negedge clk);

    // clipped length: 4095 -> 2048 words per bank, 8192 words total
    start_load(4'hC, 4095);
    b0 = busy_cnt;
    stream(8192, 8'h00, 1, 1'b0, 1'b0);
    check("clip_done", load_done, 1);
    check("clip_load_cycles", busy_cnt - b0, 8192);
`ifdef WEIGHT_MEM_CHKSUM_EN
    check("clip_chksum", load_checksum, 16'hF000);
`endif
    @(negedge clk);
    check("clip_layer", loaded_layer, 12);
    rd_chk("clip_a2047", 2047, 32'hFFFEFDFC);
    rd_chk("clip_a0", 0, 32'h03020100);
    rd_en = 1'b0;
    @(negedge clk);

    // reset in the middle of a load, then a fresh load
    start_load(4'h7, 3);
    stream(5, 8'h55, 1, 1'b0, 1'b0);
    check("mid_busy_before", load_busy, 1);
    rst_n = 1'b0;
    #1;
    reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_load(4'h3, 2);
    stream(8, 8'h11, 1, 1'b0, 1'b0);
    check("after_rst_done", load_done, 1);
    @(negedge clk);
    check("after_rst_loaded", loaded, 1);
    check("after_rst_layer", loaded_layer, 3);
    rd_chk("after_rst_a0", 0, 32'h14131211);
    rd_chk("after_rst_a1", 1, 32'h18171615);
    rd_chk("after_rst_a2", 2, 32'h0B0A0908);
    rd_en = 1'b0;
    @(negedge clk);

`ifdef WEIGHT_MEM_CHKSUM_EN
    // checksum wrap: 300 words of 0xFF
    start_load(4'h1, 75);
    stream(300, 8'hFF, 0, 1'b0, 1'b0);
    check("chk_done", load_done, 1);
    check("chk_ff300", load_checksum, 16'h2AD4);
    @(negedge clk);
    check("chk_ff300_stable", load_checksum, 16'h2AD4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_bank_array.md
# weight_bank_array

Synthesizable multi-bank weight store for the ECG accelerator. It holds NUM_BANKS parallel weight banks, loaded per layer from a valid/ready word stream. The stream is distributed round-robin across the banks. Reads deliver one word from every bank in the same cycle to the PE array. It replaces the per-bank, simulation-only file-loaded memories with one block that a host or DMA loader can fill at run time.

## Interface
- NUM_BANKS, 4, number of parallel banks (≥1)
- DATA_WIDTH, 8, bits per weight word
- ADDR_WIDTH, 11, per-bank address width
- DATA_DEPTH, 2048, words per bank (≤ 2^ADDR_WIDTH)
- LAYER_W, 4, width of layer tag
---
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- csen  in  1  chip enable; gates both reads and load-stream acceptance
- load_start  in  1  one-cycle pulse; starts a load
- load_layer  in  LAYER_W  layer tag, sampled with load_start
- load_len  in  ADDR_WIDTH+1  words per bank, sampled with load_start
- wr_valid  in  1  stream word valid
- wr_ready  out  1  stream word accepted when wr_valid & wr_ready
- wr_data  in  DATA_WIDTH  stream word
- load_busy  out  1  high in LOAD state
- load_done  out  1  one-cycle pulse at end of load
- loaded_layer  out  LAYER_W  tag of the last completed load
- loaded  out  1  at least one load has completed since reset
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  per-bank read address
- rd_valid  out  1  rd_data valid
- rd_data  out  NUM_BANKS*DATA_WIDTH  bank k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

## Operation
- FSM states: IDLE, LOAD, DONE.
- **IDLE:**
  - load_start & csen: latch tag; latch len = min(load_len, DATA_DEPTH); clear bank_ptr and addr_ptr.
  - Next state is LOAD, or DONE if len==0.
- **LOAD:**
  - wr_ready = csen.
  - Each accepted word is written to bank[bank_ptr][addr_ptr].
  - bank_ptr increments; on wrap from NUM_BANKS-1 to 0, addr_ptr increments.
  - The accepted word with bank_ptr==NUM_BANKS-1 and addr_ptr==len-1 is the last word; next state is DONE.
  - load_start is ignored while in LOAD.
- **DONE:**
  - Stays one cycle.
  - load_done=1; loaded_layer ← tag; loaded ← 1.
  - Next state is IDLE.
- **Reads:**
  - Accepted only when rd_en & csen & state==IDLE.
  - Otherwise the next-cycle rd_data=0 and rd_valid=0. A read requested during LOAD or DONE is dropped, not queued.
  - rd_addr ≥ DATA_DEPTH returns 0, with rd_valid=1.
- **Memory contents:**
  - The storage arrays are not reset; they are inferred as block RAM, one array per bank.
  - Contents are undefined until written.
  - Words not rewritten by a shorter load keep their old values.
- **Reset mid-load:** returns to IDLE. loaded and loaded_layer clear. Partially written contents stay in memory.

## Timing
- **Reset values:**
  - wr_ready, load_busy, load_done, rd_valid, loaded: 0.
  - loaded_layer: 0.
  - rd_data: 0.
- **Load sequence:** load_start at cycle t gives LOAD (load_busy=1, wr_ready=1) from t+1.
- **Write latency:** a word accepted at cycle c is readable by a read issued at c+2 or later. This is guaranteed, because DONE always precedes IDLE.
- **Load duration:** a full-rate load of len words per bank takes len*NUM_BANKS cycles in LOAD. load_done is asserted in the following cycle, and IDLE is reached one cycle after that.
- **Read latency:** 1 cycle. rd_en at t gives rd_data and rd_valid at t+1.
- **Back-to-back reads:** supported every cycle.
- **wr_ready** is combinational from state and csen only; it never depends on wr_valid.

## Configuration
- **WEIGHT_MEM_CHKSUM_EN defined:**
  - Adds output load_checksum [15:0].
  - It is the mod-2^16 sum of all words accepted in the current load, zero-extended.
  - It clears on load_start and is stable from the load_done cycle until the next load_start.
  - Reset value 0.
- **WEIGHT_MEM_CHKSUM_EN undefined:** the port and adder are absent. All other behaviour is identical.

## Test plan
- **Basic load:** NUM_BANKS=4, load_len=3, 12 words 0x01..0x0C streamed at full rate. Then read addr 0,1,2 → rd_data = 0x04030201, 0x08070605, 0x0C0B0A09. load_done pulses exactly once, 12 cycles after the first LOAD cycle. loaded_layer equals the sampled tag.
- **Backpressure and gaps:** toggle wr_valid randomly; drop csen for 3 cycles mid-load → wr_ready=0 while csen=0, no words lost or duplicated, same final contents as the basic load.
- **Blocked reads:** rd_en held high during LOAD → rd_valid=0 and rd_data=0 throughout. The first valid read appears one cycle after the first IDLE cycle in which rd_en is high.
- **Edge lengths:** load_len=0 → load_done the cycle after LOAD is skipped, memory unchanged. load_len=4095 → clipped to 2048; 8192 words are accepted and addr 2047 holds the last four words. rd_addr=2048 (ADDR_WIDTH=12 variant) → rd_data=0, rd_valid=1.
- **Reset mid-load:** assert rst_n low after 5 words → all outputs at reset values, loaded=0. A new load afterwards completes normally.
- **Checksum (macro defined):** words 0xFF ×300 → load_checksum=0x2AD4 at load_done.
